// File: rtl/edge_shift_register.sv
// rtl/edge_shift_register.sv - edge-selectable universal shift register with serial fill count
module edge_shift_register #(
    parameter int WIDTH   = 8,
    parameter bit NEGEDGE = 1'b1,
    localparam int CW     = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic [CW-1:0]    count,
    output logic             full
);

    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_LOAD  = 3'b001;
    localparam logic [2:0] MODE_SHL   = 3'b010;
    localparam logic [2:0] MODE_SHR   = 3'b011;
    localparam logic [2:0] MODE_ROTL  = 3'b100;
    localparam logic [2:0] MODE_ROTR  = 3'b101;
    localparam logic [2:0] MODE_CLEAR = 3'b110;

    localparam logic [CW-1:0] COUNT_MAX = CW'(WIDTH);

    logic [WIDTH-1:0] r_q;
    logic             r_sout;
    logic [CW-1:0]    r_count;

    logic [WIDTH-1:0] w_q_next;
    logic             w_sout_next;
    logic [CW-1:0]    w_count_next;
    logic [CW-1:0]    w_count_inc;
    logic             w_full;

    assign w_full      = (r_count == COUNT_MAX);
    assign w_count_inc = w_full ? r_count : r_count + 1'b1;

    // Next-state selection from pre-edge state; disabled or unlisted modes hold everything
    always_comb begin
        w_q_next     = r_q;
        w_sout_next  = r_sout;
        w_count_next = r_count;
        if (en) begin
            case (mode)
                MODE_LOAD: begin
                    w_q_next     = d;
                    w_count_next = COUNT_MAX;
                end
                MODE_SHL: begin
                    w_q_next     = {r_q[WIDTH-2:0], sin};
                    w_sout_next  = r_q[WIDTH-1];
                    w_count_next = w_count_inc;
                end
                MODE_SHR: begin
                    w_q_next     = {sin, r_q[WIDTH-1:1]};
                    w_sout_next  = r_q[0];
                    w_count_next = w_count_inc;
                end
                MODE_ROTL: begin
                    w_q_next    = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                    w_sout_next = r_q[WIDTH-1];
                end
                MODE_ROTR: begin
                    w_q_next    = {r_q[0], r_q[WIDTH-1:1]};
                    w_sout_next = r_q[0];
                end
                MODE_CLEAR: begin
                    w_q_next     = '0;
                    w_sout_next  = 1'b0;
                    w_count_next = '0;
                end
                MODE_HOLD: begin
                    w_q_next = r_q;
                end
                default: begin
                    w_q_next = r_q;
                end
            endcase
        end
    end

    generate
        if (NEGEDGE) begin : g_negedge
            // State capture on the falling edge, asynchronous clear
            always_ff @(negedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_q     <= '0;
                    r_sout  <= 1'b0;
                    r_count <= '0;
                end else begin
                    r_q     <= w_q_next;
                    r_sout  <= w_sout_next;
                    r_count <= w_count_next;
                end
            end
        end else begin : g_posedge
            // State capture on the rising edge, asynchronous clear
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_q     <= '0;
                    r_sout  <= 1'b0;
                    r_count <= '0;
                end else begin
                    r_q     <= w_q_next;
                    r_sout  <= w_sout_next;
                    r_count <= w_count_next;
                end
            end
        end
    endgenerate

    assign q     = r_q;
    assign sout  = r_sout;
    assign count = r_count;
    assign full  = w_full;

endmodule

// File: tb/tb_edge_shift_register.sv
// tb/tb_edge_shift_register.sv - self-checking bench for edge_shift_register
module tb_edge_shift_register;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic [2:0]    mode = 3'b000;
    logic [W-1:0]  d = '0;
    logic          sin = 1'b0;
    logic [W-1:0]  q;
    logic          sout;
    logic [CW-1:0] count;
    logic          full;

    logic          p_en = 1'b0;
    logic [2:0]    p_mode = 3'b000;
    logic [W-1:0]  p_d = '0;
    logic          p_sin = 1'b0;
    logic [W-1:0]  p_q;
    logic          p_sout;
    logic [CW-1:0] p_count;
    logic          p_full;

    int n_checks = 0;
    int n_errors = 0;

    // reference state: plain integers
    int m_q = 0;
    int m_sout = 0;
    int m_count = 0;

    always #5 clk = ~clk;

    edge_shift_register #(.WIDTH(W), .NEGEDGE(1'b1)) u_neg (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .d(d), .sin(sin),
        .q(q), .sout(sout), .count(count), .full(full)
    );

    edge_shift_register #(.WIDTH(W), .NEGEDGE(1'b0)) u_pos (
        .clk(clk), .rst_n(rst_n), .en(p_en), .mode(p_mode), .d(p_d), .sin(p_sin),
        .q(p_q), .sout(p_sout), .count(p_count), .full(p_full)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".q"},     32'(q),     32'(m_q));
        check({tag, ".sout"},  32'(sout),  32'(m_sout));
        check({tag, ".count"}, 32'(count), 32'(m_count));
        check({tag, ".full"},  32'(full),  32'(m_count == W));
    endtask

    // behavioural reference of one capture edge
    task automatic model_step(input int e, input int md, input int dd, input int s);
        int mask;
        mask = (1 << W) - 1;
        if (e == 0) return;
        case (md)
            1: begin m_q = dd; m_count = W; end
            2: begin
                m_sout = (m_q >> (W - 1)) & 1;
                m_q = ((m_q << 1) | s) & mask;
                m_count = (m_count + 1 > W) ? W : m_count + 1;
            end
            3: begin
                m_sout = m_q & 1;
                m_q = (m_q >> 1) | (s << (W - 1));
                m_count = (m_count + 1 > W) ? W : m_count + 1;
            end
            4: begin
                m_sout = (m_q >> (W - 1)) & 1;
                m_q = ((m_q << 1) | (m_q >> (W - 1))) & mask;
            end
            5: begin
                m_sout = m_q & 1;
                m_q = (m_q >> 1) | ((m_q & 1) << (W - 1));
            end
            6: begin m_q = 0; m_sout = 0; m_count = 0; end
            default: ;
        endcase
    endtask

    // drive on posedge, check nothing moved before the falling edge, check result after it
    task automatic do_op(input string tag, input logic e, input logic [2:0] md,
                         input logic [W-1:0] dd, input logic s);
        @(posedge clk);
        #1;
        check({tag, ".pre"}, 32'(q), 32'(m_q));
        en = e; mode = md; d = dd; sin = s;
        #2;
        check({tag, ".setup"}, 32'(q), 32'(m_q));
        model_step(int'(e), int'(md), int'(dd), int'(s));
        @(negedge clk);
        #1;
        check_model(tag);
    endtask

    task automatic pulse_reset(input string tag);
        @(posedge clk);
        #1;
        en = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check({tag, ".q"},     32'(q),     32'h0);
        check({tag, ".sout"},  32'(sout),  32'h0);
        check({tag, ".count"}, 32'(count), 32'h0);
        check({tag, ".full"},  32'(full),  32'h0);
        rst_n = 1'b1;
        m_q = 0; m_sout = 0; m_count = 0;
    endtask

    logic [7:0] fill_bits;
    logic [7:0] sout_exp;

    initial begin
        // reset state
        #3;
        check("rst.q", 32'(q), 32'h0);
        check("rst.count", 32'(count), 32'h0);
        check("rst.full", 32'(full), 32'h0);
        check("rst.pq", 32'(p_q), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 1. reset and edge select (falling-edge instance)
        do_op("t1.loadA5", 1'b1, 3'b001, 8'hA5, 1'b0);
        check("t1.A5", 32'(q), 32'hA5);
        pulse_reset("t1.rst");
        do_op("t1.load3C", 1'b1, 3'b001, 8'h3C, 1'b0);
        check("t1.3C", 32'(q), 32'h3C);

        // 1b. rising-edge instance changes only at posedge
        @(negedge clk);
        #1;
        p_en = 1'b1; p_mode = 3'b001; p_d = 8'h3C;
        #2;
        check("t1p.before", 32'(p_q), 32'h0);
        @(posedge clk);
        #1;
        check("t1p.after", 32'(p_q), 32'h3C);
        p_en = 1'b0;
        @(negedge clk);
        #1;
        check("t1p.neg", 32'(p_q), 32'h3C);
        check("t1p.count", 32'(p_count), 32'(W));

        // 2. serial fill
        do_op("t2.clr", 1'b1, 3'b110, 8'h00, 1'b0);
        fill_bits = 8'b1011_0010;
        for (int i = 0; i < 8; i++) begin
            do_op("t2.shl", 1'b1, 3'b010, 8'h00, fill_bits[7 - i]);
            check("t2.cnt", 32'(count), 32'(i + 1));
        end
        check("t2.B2", 32'(q), 32'hB2);
        check("t2.full", 32'(full), 32'h1);
        do_op("t2.ninth", 1'b1, 3'b010, 8'h00, 1'b1);
        check("t2.65", 32'(q), 32'h65);
        check("t2.sout", 32'(sout), 32'h1);
        check("t2.sat", 32'(count), 32'(W));

        // 3. parallel to serial
        do_op("t3.load", 1'b1, 3'b001, 8'h81, 1'b0);
        sout_exp = 8'b1000_0001;
        for (int i = 0; i < 8; i++) begin
            do_op("t3.shr", 1'b1, 3'b011, 8'h00, 1'b0);
            check("t3.sout", 32'(sout), 32'(sout_exp[7 - i]));
            check("t3.cnt", 32'(count), 32'(W));
        end
        check("t3.q", 32'(q), 32'h0);

        // 4. rotate
        do_op("t4.load", 1'b1, 3'b001, 8'h96, 1'b0);
        for (int i = 0; i < 3; i++) do_op("t4.rotl", 1'b1, 3'b100, 8'h00, 1'b1);
        check("t4.B4", 32'(q), 32'hB4);
        check("t4.sout", 32'(sout), 32'h0);
        for (int i = 0; i < 3; i++) do_op("t4.rotr", 1'b1, 3'b101, 8'h00, 1'b1);
        check("t4.96", 32'(q), 32'h96);
        check("t4.cnt", 32'(count), 32'(W));

        // 5. enable and reserved
        for (int i = 0; i < 8; i++) begin
            do_op("t5.dis", 1'b0, 3'(i), 8'hFF, 1'b1);
            check("t5.dis.q", 32'(q), 32'h96);
        end
        do_op("t5.rsv", 1'b1, 3'b111, 8'hFF, 1'b1);
        check("t5.rsv.q", 32'(q), 32'h96);
        do_op("t5.clr", 1'b1, 3'b110, 8'hFF, 1'b1);
        check("t5.clr.q", 32'(q), 32'h0);
        check("t5.clr.full", 32'(full), 32'h0);

        // 6. reset mid-fill
        for (int i = 0; i < 5; i++) do_op("t6.fill", 1'b1, 3'b010, 8'h00, 1'b1);
        pulse_reset("t6.rst");
        do_op("t6.b0", 1'b1, 3'b010, 8'h00, 1'b1);
        do_op("t6.b1", 1'b1, 3'b010, 8'h00, 1'b1);
        do_op("t6.b2", 1'b1, 3'b010, 8'h00, 1'b0);
        check("t6.cnt", 32'(count), 32'h3);
        check("t6.full", 32'(full), 32'h0);
        check("t6.q", 32'(q), 32'h06);

        // randomized operations against the reference
        for (int i = 0; i < 300; i++) begin
            do_op("rnd", ($urandom_range(0, 7) != 0), 3'($urandom_range(0, 7)),
                  W'($urandom), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/edge_shift_register.md
# edge_shift_register

Parametrised, edge-selectable universal shift register; the next generation of the team's single-bit falling-edge D flip-flop. It stores a WIDTH-bit word captured on a configurable clock edge and supports hold, parallel load, logical shift, rotate and clear. It also tracks how many serial bits have filled the register. It serves as the storage and serialiser/deserialiser element between the datapath and bit-serial links.

## Interface
- WIDTH, 8: register width in bits, ≥ 2.
- NEGEDGE, 1: capture edge. 1 = falling edge of clk, 0 = rising edge.
- CW, $clog2(WIDTH+1): width of count (derived, not overridden).

- clk  input  1: clock. The capture edge is selected by NEGEDGE.
- rst_n  input  1: reset. Asynchronous, active-low.
- en  input  1: operation enable. 0 = hold everything.
- mode  input  3: operation select, sampled at the capture edge.
- d  input  WIDTH: parallel load data.
- sin  input  1: serial input bit.
- q  output  WIDTH: register contents.
- sout  output  1: registered copy of the last bit shifted or rotated out.
- count  output  CW: serial fill count, 0..WIDTH.
- full  output  1: high when count == WIDTH (combinational from count).

## Operation
- Reset: rst_n low forces q=0, sout=0, count=0 and full=0 immediately, independent of clk. This applies for either NEGEDGE value.
- All state updates occur only at the selected capture edge, when rst_n is high and en is 1.
- Modes:
  - 000 hold: no state change.
  - 001 load: q←d, count←WIDTH, sout unchanged.
  - 010 shift left: q←{q[WIDTH-2:0],sin}, sout←q[WIDTH-1], count←min(count+1,WIDTH).
  - 011 shift right: q←{sin,q[WIDTH-1:1]}, sout←q[0], count←min(count+1,WIDTH).
  - 100 rotate left: q←{q[WIDTH-2:0],q[WIDTH-1]}, sout←q[WIDTH-1], count unchanged.
  - 101 rotate right: q←{q[0],q[WIDTH-1:1]}, sout←q[0], count unchanged.
  - 110 clear: q←0, count←0, sout←0.
  - 111 reserved: behaves exactly as hold.
- count saturates at WIDTH. Further shifts keep count=WIDTH and full=1.
- Shifts use the pre-edge q for both the new q and sout; no intermediate values are visible.
- en=0 overrides mode: all state holds.
- X or Z on mode with en=1 is a bench error. The RTL treats any unlisted encoding as hold.

## Timing
- Latency: one capture edge. q, sout and count reflect the operation sampled at edge N immediately after edge N.
- Outputs never change on the non-selected clock edge. With NEGEDGE=1, a bench sampling on posedge sees stable values.
- Inputs must be stable around the capture edge. With NEGEDGE=1, drive inputs on posedge to get half-cycle setup.
- Reset assertion is asynchronous. Deassertion must meet recovery to the capture edge. The first operation executes at the first capture edge with rst_n high.
- Reset asserted mid-sequence, e.g. during a serial fill, aborts it. count returns to 0 and no partial word is retained.
- full rises in the same cycle count reaches WIDTH, i.e. after the WIDTH-th shift since the last reset or clear with no intervening load.

## Test plan
1. Reset and edge select: WIDTH=8, NEGEDGE=1. Load d=8'hA5, then pulse rst_n low between edges → q=00, count=0, sout=0 immediately. A load of 8'h3C changes q only at the falling edge, never at a rising edge. Repeat with NEGEDGE=0: q changes only at the rising edge.
2. Serial fill: after clear, shift left 8× with sin pattern 1,0,1,1,0,0,1,0 → q=8'hB2, count steps 1..8, full=1 after the 8th edge. A 9th shift (sin=1) gives q=8'h65, sout=1, count stays 8.
3. Parallel to serial: load 8'h81, then shift right 8× with sin=0 → sout sequence 1,0,0,0,0,0,0,1 and final q=00. count stays 8 throughout (load set it to 8, shifts saturate).
4. Rotate: load 8'h96, rotate left 3× → q=8'hB4, sout=0 after the last step. Rotate right 3× → q=8'h96. count stays 8.
5. Enable and reserved: with en=0, apply each mode with d=8'hFF → no change. With en=1 and mode=111 → no change. Clear → q=00, count=0, full=0.
6. Reset mid-fill: shift in 5 bits, assert rst_n, release, shift in 3 bits → count=3, full=0, and q holds only the 3 new bits.
